// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, phase encoding and complex sample type for the SDF butterfly
package fft_pkg;

    localparam int DATA_W = 24;
    localparam int FRAC_W = 8;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BFLY = 2'd1,
        ST_TWID = 2'd2,
        ST_RSVD = 2'd3
    } phase_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/radix2_sdf_bf8_cmplx_mult.sv
// rtl/radix2_sdf_bf8_cmplx_mult.sv - combinational fixed-point complex multiply, floor or round-half-up (SDF_BF8_ROUND_EN)
module cmplx_mult #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 8
) (
    input  logic signed [DATA_W-1:0] a_r,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_r,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] p_r,
    output logic signed [DATA_W-1:0] p_i
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] rr;
    logic signed [PROD_W-1:0] ii;
    logic signed [PROD_W-1:0] ri;
    logic signed [PROD_W-1:0] ir;
    logic signed [SUM_W-1:0]  sum_r;
    logic signed [SUM_W-1:0]  sum_i;

    assign rr = a_r * b_r;
    assign ii = a_i * b_i;
    assign ri = a_r * b_i;
    assign ir = a_i * b_r;

    // One guard bit keeps the sum of two full-width products exact before scaling.
    assign sum_r = $signed({rr[PROD_W-1], rr}) - $signed({ii[PROD_W-1], ii});
    assign sum_i = $signed({ri[PROD_W-1], ri}) + $signed({ir[PROD_W-1], ir});

`ifdef SDF_BF8_ROUND_EN
    localparam logic signed [SUM_W-1:0] HALF_LSB = SUM_W'(1) <<< (FRAC_W - 1);

    assign p_r = DATA_W'((sum_r + HALF_LSB) >>> FRAC_W);
    assign p_i = DATA_W'((sum_i + HALF_LSB) >>> FRAC_W);
`else
    assign p_r = DATA_W'(sum_r >>> FRAC_W);
    assign p_i = DATA_W'(sum_i >>> FRAC_W);
`endif

endmodule

// File: rtl/radix2_sdf_bf8.sv
// rtl/radix2_sdf_bf8.sv - radix-2 single-path delay-feedback butterfly stage, 8-deep feedback (SDF_BF8_ROUND_EN selects product rounding)
module radix2_sdf_bf8
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int DEPTH  = fft_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic [1:0]               state,
    input  logic signed [DATA_W-1:0] w_r,
    input  logic signed [DATA_W-1:0] w_i,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i
);

    logic signed [DATA_W-1:0] dl_r [DEPTH];
    logic signed [DATA_W-1:0] dl_i [DEPTH];

    logic signed [DATA_W-1:0] head_r;
    logic signed [DATA_W-1:0] head_i;
    logic signed [DATA_W-1:0] prod_r;
    logic signed [DATA_W-1:0] prod_i;
    logic signed [DATA_W-1:0] push_r;
    logic signed [DATA_W-1:0] push_i;
    logic signed [DATA_W-1:0] nxt_r;
    logic signed [DATA_W-1:0] nxt_i;
    logic                     nxt_valid;
    logic                     advance;
    phase_t                   phase;

    assign phase  = phase_t'(state);
    assign head_r = dl_r[0];
    assign head_i = dl_i[0];

    cmplx_mult #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_cmplx_mult (
        .a_r (head_r),
        .a_i (head_i),
        .b_r (w_r),
        .b_i (w_i),
        .p_r (prod_r),
        .p_i (prod_i)
    );

    always_comb begin
        advance   = 1'b0;
        push_r    = din_r;
        push_i    = din_i;
        nxt_r     = dout_r;
        nxt_i     = dout_i;
        nxt_valid = 1'b0;
        case (phase)
            ST_FILL: begin
                advance = in_valid;
            end
            ST_BFLY: begin
                advance   = 1'b1;
                push_r    = head_r - din_r;
                push_i    = head_i - din_i;
                nxt_r     = head_r + din_r;
                nxt_i     = head_i + din_i;
                nxt_valid = 1'b1;
            end
            ST_TWID: begin
                advance   = 1'b1;
                nxt_r     = prod_r;
                nxt_i     = prod_i;
                nxt_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Entry 0 is the oldest sample; every advance shifts toward it and refills the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                dl_r[k] <= dl_r[k+1];
                dl_i[k] <= dl_i[k+1];
            end
            dl_r[DEPTH-1] <= push_r;
            dl_i[DEPTH-1] <= push_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r    <= '0;
            dout_i    <= '0;
            out_valid <= 1'b0;
        end else begin
            dout_r    <= nxt_r;
            dout_i    <= nxt_i;
            out_valid <= nxt_valid;
        end
    end

endmodule

// File: tb/tb_radix2_sdf_bf8.sv
// tb/tb_radix2_sdf_bf8.sv - self-checking bench for radix2_sdf_bf8 against a queue-based reference model
module tb_radix2_sdf_bf8;

    localparam int W = 24;
    localparam int D = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] din_r = '0;
    logic signed [W-1:0] din_i = '0;
    logic [1:0]          state = 2'd0;
    logic signed [W-1:0] w_r = '0;
    logic signed [W-1:0] w_i = '0;
    logic                out_valid;
    logic signed [W-1:0] dout_r;
    logic signed [W-1:0] dout_i;

    int n_cmp = 0;
    int n_err = 0;

    longint              qr[$];
    longint              qi[$];
    logic signed [W-1:0] m_r;
    logic signed [W-1:0] m_i;
    logic                m_v;

    radix2_sdf_bf8 #(.DATA_W(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .state     (state),
        .w_r       (w_r),
        .w_i       (w_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    always #5 clk = ~clk;

    function automatic longint wrap(input longint x);
        longint m;
        m = x & ((64'sd1 <<< W) - 1);
        if (m >= (64'sd1 <<< (W - 1)))
            m = m - (64'sd1 <<< W);
        return m;
    endfunction

    // Fixed-point rescale of a full-precision product sum: floor(s / 256), or with +128 when rounding.
    function automatic longint rescale(input longint s);
        longint t;
        t = s;
`ifdef SDF_BF8_ROUND_EN
        t = t + 128;
`endif
        return wrap(t >>> 8);
    endfunction

    task automatic model_reset();
        qr.delete();
        qi.delete();
        for (int k = 0; k < D; k++) begin
            qr.push_back(0);
            qi.push_back(0);
        end
        m_r = '0;
        m_i = '0;
        m_v = 1'b0;
    endtask

    task automatic apply_reset();
        state    = 2'd0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drive one clock of inputs and advance the reference model by the same step.
    task automatic cycle(input logic [1:0] st, input logic iv, input longint dr_in, input longint di_in,
                         input longint wr_in, input longint wi_in);
        longint dr, di, wr, wi, hr, hi, t;
        dr = wrap(dr_in); di = wrap(di_in); wr = wrap(wr_in); wi = wrap(wi_in);
        state = st; in_valid = iv;
        din_r = dr[W-1:0]; din_i = di[W-1:0];
        w_r = wr[W-1:0]; w_i = wi[W-1:0];
        @(posedge clk);
        #1;
        hr = qr[0];
        hi = qi[0];
        case (st)
            2'd0: begin
                if (iv) begin
                    void'(qr.pop_front()); void'(qi.pop_front());
                    qr.push_back(dr); qi.push_back(di);
                end
                m_v = 1'b0;
            end
            2'd1: begin
                void'(qr.pop_front()); void'(qi.pop_front());
                qr.push_back(wrap(hr - dr)); qi.push_back(wrap(hi - di));
                t = wrap(hr + dr); m_r = t[W-1:0];
                t = wrap(hi + di); m_i = t[W-1:0];
                m_v = 1'b1;
            end
            2'd2: begin
                void'(qr.pop_front()); void'(qi.pop_front());
                qr.push_back(dr); qi.push_back(di);
                t = rescale(hr * wr - hi * wi); m_r = t[W-1:0];
                t = rescale(hr * wi + hi * wr); m_i = t[W-1:0];
                m_v = 1'b1;
            end
            default: m_v = 1'b0;
        endcase
    endtask

    task automatic test_reset();
        cycle(2'd1, 1'b0, 1234, 55, 0, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (dout_r !== '0) begin n_err++; $display("FAIL reset_dout_r got %0d want 0", dout_r); end
        n_cmp++; if (dout_i !== '0) begin n_err++; $display("FAIL reset_dout_i got %0d want 0", dout_i); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(2'd3, 1'b1, 99, 99, 0, 0);
            n_cmp++; if (out_valid !== 1'b0 || dout_r !== '0) begin
                n_err++; $display("FAIL reset_idle got v=%0b r=%0d want v=0 r=0", out_valid, dout_r);
            end
        end
    endtask

    task automatic test_fill_bfly_twid();
        logic signed [W-1:0] e;
        apply_reset();
        for (int k = 1; k <= D; k++) begin
            cycle(2'd0, 1'b1, longint'(k * 256), 0, 0, 0);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_valid k=%0d got %0b want 0", k, out_valid); end
        end
        for (int k = 0; k < D; k++) begin
            cycle(2'd1, 1'b0, 2560, 0, 0, 0);
            e = W'((11 + k) * 256);
            n_cmp++; if (out_valid !== 1'b1 || dout_r !== e || dout_i !== '0) begin
                n_err++; $display("FAIL bfly k=%0d got v=%0b r=%0d i=%0d want v=1 r=%0d i=0", k, out_valid, dout_r, dout_i, e);
            end
        end
        for (int k = 0; k < D; k++) begin
            cycle(2'd2, 1'b0, 0, 0, 0, -256);
            e = W'((9 - k) * 256);
            n_cmp++; if (out_valid !== 1'b1 || dout_r !== '0 || dout_i !== e) begin
                n_err++; $display("FAIL twid k=%0d got v=%0b r=%0d i=%0d want v=1 r=0 i=%0d", k, out_valid, dout_r, dout_i, e);
            end
        end
        cycle(2'd3, 1'b0, 0, 0, 0, 0);
        n_cmp++; if (out_valid !== 1'b0 || dout_i !== W'(2 * 256)) begin
            n_err++; $display("FAIL twid_hold got v=%0b i=%0d want v=0 i=512", out_valid, dout_i);
        end
    endtask

    task automatic test_rounding();
        logic signed [W-1:0] e_pos, e_neg;
`ifdef SDF_BF8_ROUND_EN
        e_pos = W'(2);  e_neg = W'(-1);
`else
        e_pos = W'(1);  e_neg = W'(-2);
`endif
        apply_reset();
        cycle(2'd0, 1'b1, 3, 0, 0, 0);
        cycle(2'd0, 1'b1, -3, 0, 0, 0);
        for (int k = 2; k < D; k++) cycle(2'd0, 1'b1, 0, 0, 0, 0);
        cycle(2'd2, 1'b0, 0, 0, 128, 0);
        n_cmp++; if (dout_r !== e_pos) begin n_err++; $display("FAIL round_pos got %0d want %0d", dout_r, e_pos); end
        cycle(2'd2, 1'b0, 0, 0, 128, 0);
        n_cmp++; if (dout_r !== e_neg) begin n_err++; $display("FAIL round_neg got %0d want %0d", dout_r, e_neg); end
    endtask

    task automatic test_fill_stall();
        logic signed [W-1:0] e;
        apply_reset();
        for (int k = 0; k < 2 * D; k++) begin
            cycle(2'd0, (k % 2) == 0, (k % 2) == 0 ? longint'(100 + k) : 64'sd7777, 3, 0, 0);
            n_cmp++; if (out_valid !== 1'b0 || dout_r !== '0) begin
                n_err++; $display("FAIL stall_fill k=%0d got v=%0b r=%0d want v=0 r=0", k, out_valid, dout_r);
            end
        end
        for (int k = 0; k < D; k++) begin
            cycle(2'd1, 1'b0, 0, 0, 0, 0);
            e = W'(100 + 2 * k);
            n_cmp++; if (dout_r !== e || dout_i !== W'(3)) begin
                n_err++; $display("FAIL stall_out k=%0d got r=%0d i=%0d want r=%0d i=3", k, dout_r, dout_i, e);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        cycle(2'd0, 1'b1, 64'h7FFFFF, 0, 0, 0);
        for (int k = 1; k < D; k++) cycle(2'd0, 1'b1, 0, 0, 0, 0);
        cycle(2'd1, 1'b0, 1, 0, 0, 0);
        n_cmp++; if (dout_r !== 24'h800000) begin n_err++; $display("FAIL wrap got %h want 800000", dout_r); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int k = 0; k < D; k++) cycle(2'd0, 1'b1, longint'($urandom), longint'($urandom), 0, 0);
        for (int k = 0; k < 3; k++) cycle(2'd2, 1'b0, longint'($urandom), 0, 256, 256);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
            n_err++; $display("FAIL midrst_clear got v=%0b r=%0d i=%0d want all 0", out_valid, dout_r, dout_i);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < D; k++) begin
            cycle(2'd1, 1'b0, 5, 0, 0, 0);
            n_cmp++; if (out_valid !== 1'b1 || dout_r !== W'(5) || dout_i !== '0) begin
                n_err++; $display("FAIL midrst_bfly k=%0d got v=%0b r=%0d i=%0d want v=1 r=5 i=0", k, out_valid, dout_r, dout_i);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < D; k++) cycle(2'd0, 1'b1, longint'($urandom), longint'($urandom), 0, 0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 2 * D; k++) begin
                cycle(k < D ? 2'd1 : 2'd2, 1'($urandom), longint'($urandom), longint'($urandom),
                      longint'($urandom), longint'($urandom));
                n_cmp++; if (out_valid !== m_v || dout_r !== m_r || dout_i !== m_i) begin
                    n_err++; $display("FAIL b2b blk=%0d k=%0d got v=%0b r=%0d i=%0d want v=%0b r=%0d i=%0d",
                                      b, k, out_valid, dout_r, dout_i, m_v, m_r, m_i);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(2'($urandom), 1'($urandom), longint'($urandom), longint'($urandom),
                  longint'($urandom_range(0, 1023)) - 512, longint'($urandom_range(0, 1023)) - 512);
            n_cmp++; if (out_valid !== m_v || dout_r !== m_r || dout_i !== m_i) begin
                n_err++; $display("FAIL random n=%0d st=%0d got v=%0b r=%0d i=%0d want v=%0b r=%0d i=%0d",
                                  n, state, out_valid, dout_r, dout_i, m_v, m_r, m_i);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_bfly_twid();
        test_rounding();
        test_fill_stall();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/radix2_sdf_bf8.md
RADIX2_SDF_BF8 -- requirements
Module: radix2_sdf_bf8

Interface
REQ-001 Reset rst_n, asynchronous, active-low; clock clk.
REQ-002 Parameter DATA_W, default 24: signed data/twiddle width, fixed point with 8 fractional bits.
REQ-003 Parameter DEPTH, default 8: feedback delay-line length in samples.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 in_valid  input  1  din_r/din_i carry a sample this cycle.
REQ-007 din_r, din_i  input  DATA_W  signed input sample, real/imag.
REQ-008 state  input  2  phase from upstream twiddle ROM: 0 fill, 1 butterfly, 2 twiddle-out; 3 reserved.
REQ-009 w_r, w_i  input  DATA_W  signed twiddle, 1.0 = 256.
REQ-010 out_valid  output  1  dout_r/dout_i valid this cycle.
REQ-011 dout_r, dout_i  output  DATA_W  signed output sample, registered.

Function
REQ-012 Delay line: DEPTH-entry complex shift register; head is the oldest entry; each advance pushes one complex word at tail and pops head.
REQ-013 state 0: advance only when in_valid=1, pushing din; out_valid=0 next cycle; dout holds its value.
REQ-014 state 1: advance every cycle; output sum = head + din; push difference = head - din.
REQ-015 state 2: advance every cycle; output product = head * (w_r + j*w_i); push din.
REQ-016 Complex product: pr = head_r*w_r - head_i*w_i, pi = head_r*w_i + head_i*w_r; full 2*DATA_W-bit products; result arithmetic-shifted right 8 and truncated to DATA_W.
REQ-017 Add/sub are DATA_W-bit two's-complement and wrap on overflow; there is no saturation.
REQ-018 Latency: dout/out_valid register the state-1/state-2 result one cycle after the inputs are sampled.
REQ-019 out_valid=1 in the cycle after any state-1 or state-2 cycle; otherwise 0.
REQ-020 In states 1 and 2, in_valid is ignored; din is consumed every cycle. A low in_valid is legal and pushes whatever is on din.
REQ-021 state 3: no advance; out_valid=0 next cycle; delay line and dout hold.
REQ-022 The 1->2 and 2->1 transitions need no bubble; consecutive 16-cycle blocks (8 state 1, 8 state 2) stream back to back.

Reset
REQ-023 rst_n low clears all delay-line entries, dout_r, dout_i and out_valid to 0 immediately, regardless of clk.
REQ-024 Reset asserted mid-block discards all partial results; after release the block restarts in whatever state the input presents, with a zeroed delay line.

Configuration
REQ-025 Macro SDF_BF8_ROUND_EN: when defined, add 128 to each product sum before the right shift by 8 (round half up). When undefined, truncate (floor). Add/sub paths are unaffected either way.

Structure
REQ-026 Shared package fft_pkg holds DATA_W, FRAC_W=8, DEPTH, the state encodings ST_FILL=0, ST_BFLY=1, ST_TWID=2, and the complex-sample typedef.
REQ-027 One sub-module, cmplx_mult (combinational, DATA_W inputs, shift/round per REQ-016/REQ-025), instantiated once.
REQ-028 The delay line is a register array; no memory macro is used.

Verification
REQ-029 Fill then butterfly: state 0 with in_valid for samples 1..8 (real x*256, imag 0), then state 1 with din=10*256 for 8 cycles -> out_valid rises one cycle after the first state-1 cycle; dout_r = (11..18)*256; delay line holds (-9..-2)*256.
REQ-030 Twiddle phase: continue from REQ-029 with state 2 and w = 0/-256 (-j) for 8 cycles -> dout_r=0, dout_i = (9..2)*256 (as -j*(-k)).
REQ-031 Rounding: head = (3, 0), w = (128, 0) -> dout_r=1 without SDF_BF8_ROUND_EN, 2 with it; head = (-3, 0) -> -2 truncated, -1 rounded.
REQ-032 Fill stall: state 0 with in_valid toggling 1,0,1,... -> only valid samples enter; out_valid stays 0; the first state-1 output pairs with the 1st valid sample.
REQ-033 Wrap: head_r = 0x7FFFFF, din_r = 1, state 1 -> dout_r = 0x800000; no saturation.
REQ-034 Mid-block reset: pulse rst_n low for 1 ns during state 2 -> outputs 0 at once; after release, 8 state-1 cycles with din=5 give dout_r=5 (zero head).
